dram_cmd_responder: RTL and testbench
=====================================

# dram_cmd_responder

DRAM-side command responder for the group's DDR4 memory controller: it consumes the PRE/ACT/RD/WR command stream the controller emits, one command per clock, and models 16 banks (4 bank groups × 4 banks). It tracks open rows and enforces tRP, tRCD, tWR, tRTP and tCCD_L, returning a registered per-command response code. Both simulation and a synthesizable checker use it to prove the controller's scheduling legal.

## Interface
- tRP, 24, ACT-after-PRE minimum spacing, same bank (clk cycles)
- tRCD, 24, RD/WR-after-ACT minimum spacing, same bank
- tWR, 20, PRE-after-WR minimum spacing, same bank
- tRTP, 12, PRE-after-RD minimum spacing, same bank
- tCCD_L, 8, RD/WR-after-RD/WR minimum spacing, same bank group
- CNT_W, 16, width of statistics counters
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present this cycle
- cmd_type  in  2  PRE=2'b00, ACT=2'b01, RD=2'b10, WR=2'b11
- cmd_bg  in  2  bank group
- cmd_bank  in  2  bank within group; bank index = {cmd_bg, cmd_bank}
- cmd_row  in  18  row (ACT: row to open; RD/WR: must equal open row; PRE: ignored)
- cmd_col  in  8  column (carried only, not checked)
- resp_valid  out  1  response for the previous cycle's command
- resp_code  out  4  result code (below)
- resp_bank  out  4  bank index of the responded command
- bank_open  out  16  bit i = bank i holds an open row
- cmd_count  out  CNT_W  commands received, saturating
- err_count  out  CNT_W  commands with nonzero resp_code, saturating

## Operation
- Codes: 0 OK, 1 ACT_BANK_OPEN, 2 TRP, 3 BANK_CLOSED, 4 ROW_MISMATCH, 5 TRCD, 6 TCCD, 7 TRTP, 8 TWR.
- Per bank: state CLOSED/OPEN, open_row[17:0], timers rp_cnt, rcd_cnt, pre_cnt (5 bits each). Per bank group: ccd_cnt (4 bits).
- Timer rule: at the edge accepting a command, the timer loads tX−1; it then decrements once per cycle, saturating at 0. A dependent command is legal only in a cycle where the timer reads 0, i.e. ≥ tX cycles after its predecessor.
- ACT checks, first match wins: bank OPEN→1; rp_cnt≠0→2; else OK. On OK: state OPEN, open_row=cmd_row, rcd_cnt=tRCD−1.
- RD/WR checks, in order: bank CLOSED→3; cmd_row≠open_row→4; rcd_cnt≠0→5; group ccd_cnt≠0→6; else OK. On OK: ccd_cnt=tCCD_L−1; pre_cnt=max(pre_cnt, tRTP−1) for RD, max(pre_cnt, tWR−1) for WR.
- PRE: bank CLOSED→OK, no state change, rp_cnt untouched. Bank OPEN: pre_cnt≠0→7 if last limiting access was RD, 8 if WR (track with a 1-bit per-bank flag set by whichever access set pre_cnt). On OK: state CLOSED, rp_cnt=tRP−1.
- A command with nonzero code changes no bank state or timer. It is counted in cmd_count and err_count.
- Timers of all banks/groups decrement every cycle regardless of cmd_valid.
- Counters saturate at all-ones and never wrap.

## Timing
- One command accepted every cycle; no backpressure.
- resp_valid/resp_code/resp_bank are registered: a command in cycle N produces its response in cycle N+1. resp_valid=0 in cycles following cmd_valid=0. resp_code/resp_bank hold their last values when resp_valid=0.
- bank_open and counters update at the same edge as the response.
- Back-to-back commands to the same bank in cycles N and N+1: command N+1 sees state already updated by N.
- Reset (any time, including mid-stream): all banks CLOSED, open_row=0, every timer and flag 0, resp_valid=0, resp_code=0, resp_bank=0, bank_open=0, cmd_count=0, err_count=0. The first command after deassertion sees no timing constraints.

## Test plan
- ACT bank 5 row 0x1234 at cycle 0, RD bank 5 row 0x1234 at cycle 24 → both code 0; a repeat run with the RD at cycle 23 → code 5, err_count=1.
- RD bank 0 at cycle t, RD bank 1 (same group) at t+7 → code 6; RD bank 4 (group 1) at t+7 → code 0.
- WR bank 3 at t, PRE bank 3 at t+19 → code 8, bank_open[3] stays 1; PRE at t+20 → code 0, bank_open[3]=0. The same sequence with RD uses spacings 11/12 and yields code 7/0.
- PRE bank 2 at t, ACT bank 2 at t+23 → code 2; ACT at t+24 → code 0. ACT to an already-open bank → code 1. RD to a closed bank → code 3. RD with a row other than open_row → code 4.
- PRE to a closed bank → code 0, no rp_cnt load, so an immediate ACT returns code 0. Drive 70000 commands → cmd_count saturates at 0xFFFF.
- Assert rst_n low mid-stream with banks open and timers running → all outputs 0 asynchronously. After release, ACT+RD to the same bank 24 cycles apart → both code 0.

Source files
------------

// File: rtl/dram_cmd_responder.sv
// DDR4 command responder: checks each PRE/ACT/RD/WR command against per-bank
// row state and tRP/tRCD/tWR/tRTP/tCCD_L timers, and returns a result code.
// Latency: one cycle (response registered). Backpressure: none, one command per clock.
// Ports: cmd_* = incoming command (valid/type/bank group/bank/row/col);
//        resp_* = registered response for the previous cycle's command;
//        bank_open = per-bank open flags; cmd_count/err_count = saturating stats.
module dram_cmd_responder #(
  parameter int T_RP    = 24,
  parameter int T_RCD   = 24,
  parameter int T_WR    = 20,
  parameter int T_RTP   = 12,
  parameter int T_CCD_L = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_type,
  input  logic [1:0]       cmd_bg,
  input  logic [1:0]       cmd_bank,
  input  logic [17:0]      cmd_row,
  input  logic [7:0]       cmd_col,
  output logic             resp_valid,
  output logic [3:0]       resp_code,
  output logic [3:0]       resp_bank,
  output logic [15:0]      bank_open,
  output logic [CNT_W-1:0] cmd_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [1:0] CMD_PRE = 2'b00;
  localparam logic [1:0] CMD_ACT = 2'b01;
  localparam logic [1:0] CMD_WR  = 2'b11;

  localparam logic [3:0] RC_OK       = 4'd0;
  localparam logic [3:0] RC_ACT_OPEN = 4'd1;
  localparam logic [3:0] RC_TRP      = 4'd2;
  localparam logic [3:0] RC_CLOSED   = 4'd3;
  localparam logic [3:0] RC_ROW      = 4'd4;
  localparam logic [3:0] RC_TRCD     = 4'd5;
  localparam logic [3:0] RC_TCCD     = 4'd6;
  localparam logic [3:0] RC_TRTP     = 4'd7;
  localparam logic [3:0] RC_TWR      = 4'd8;

  // A timer loaded with tX-1 reads zero exactly tX cycles after the load.
  localparam logic [4:0] RP_LD  = 5'(T_RP - 1);
  localparam logic [4:0] RCD_LD = 5'(T_RCD - 1);
  localparam logic [4:0] WR_LD  = 5'(T_WR - 1);
  localparam logic [4:0] RTP_LD = 5'(T_RTP - 1);
  localparam logic [3:0] CCD_LD = 4'(T_CCD_L - 1);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [15:0] open_q;
  logic [17:0] open_row [16];
  logic [4:0]  rp_cnt   [16];
  logic [4:0]  rcd_cnt  [16];
  logic [4:0]  pre_cnt  [16];
  logic [15:0] pre_by_wr;     // 1: pending PRE limit came from a WR
  logic [3:0]  ccd_cnt  [4];

  logic [3:0] idx;
  logic [3:0] code;
  logic [4:0] pre_dec;
  logic [4:0] acc_ld;
  logic       acc_wins;
  logic       accept;
  logic       unused_col;

  assign unused_col = ^cmd_col;
  assign bank_open  = open_q;

  always_comb begin
    idx      = {cmd_bg, cmd_bank};
    code     = RC_OK;
    // pre_cnt as it would read next cycle, so max() keeps the older access's
    // deadline exact rather than one cycle too strict.
    pre_dec  = (pre_cnt[idx] != 5'd0) ? pre_cnt[idx] - 5'd1 : 5'd0;
    acc_ld   = (cmd_type == CMD_WR) ? WR_LD : RTP_LD;
    acc_wins = (acc_ld >= pre_dec);
    case (cmd_type)
      CMD_PRE: begin
        if (open_q[idx] && pre_cnt[idx] != 5'd0)
          code = pre_by_wr[idx] ? RC_TWR : RC_TRTP;
      end
      CMD_ACT: begin
        if (open_q[idx])                 code = RC_ACT_OPEN;
        else if (rp_cnt[idx] != 5'd0)    code = RC_TRP;
      end
      default: begin
        if (!open_q[idx])                code = RC_CLOSED;
        else if (cmd_row != open_row[idx]) code = RC_ROW;
        else if (rcd_cnt[idx] != 5'd0)   code = RC_TRCD;
        else if (ccd_cnt[cmd_bg] != 4'd0) code = RC_TCCD;
      end
    endcase
    accept = cmd_valid && (code == RC_OK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open_q     <= '0;
      pre_by_wr  <= '0;
      for (int b = 0; b < 16; b++) begin
        open_row[b] <= '0;
        rp_cnt[b]   <= '0;
        rcd_cnt[b]  <= '0;
        pre_cnt[b]  <= '0;
      end
      for (int g = 0; g < 4; g++) ccd_cnt[g] <= '0;
      resp_valid <= 1'b0;
      resp_code  <= '0;
      resp_bank  <= '0;
      cmd_count  <= '0;
      err_count  <= '0;
    end else begin
      // Free-running decrement; command loads below take precedence.
      for (int b = 0; b < 16; b++) begin
        if (rp_cnt[b]  != 5'd0) rp_cnt[b]  <= rp_cnt[b]  - 5'd1;
        if (rcd_cnt[b] != 5'd0) rcd_cnt[b] <= rcd_cnt[b] - 5'd1;
        if (pre_cnt[b] != 5'd0) pre_cnt[b] <= pre_cnt[b] - 5'd1;
      end
      for (int g = 0; g < 4; g++)
        if (ccd_cnt[g] != 4'd0) ccd_cnt[g] <= ccd_cnt[g] - 4'd1;

      if (accept) begin
        case (cmd_type)
          CMD_PRE: begin
            // PRE to a closed bank is a no-op and must not restart tRP.
            if (open_q[idx]) begin
              open_q[idx] <= 1'b0;
              rp_cnt[idx] <= RP_LD;
            end
          end
          CMD_ACT: begin
            open_q[idx]   <= 1'b1;
            open_row[idx] <= cmd_row;
            rcd_cnt[idx]  <= RCD_LD;
          end
          default: begin
            ccd_cnt[cmd_bg] <= CCD_LD;
            if (acc_wins) begin
              pre_cnt[idx]   <= acc_ld;
              pre_by_wr[idx] <= (cmd_type == CMD_WR);
            end
          end
        endcase
      end

      resp_valid <= cmd_valid;
      if (cmd_valid) begin
        resp_code <= code;
        resp_bank <= idx;
        if (cmd_count != CNT_MAX) cmd_count <= cmd_count + CNT_W'(1);
        if (code != RC_OK && err_count != CNT_MAX) err_count <= err_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dram_cmd_responder.sv
// Bench for dram_cmd_responder: directed vector table, random traffic and a
// deadline-based reference model (absolute cycle numbers per constraint).
// Ports: drives all cmd_* inputs, checks every output after each clock.
module tb_dram_cmd_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_type = '0;
  logic [1:0]  cmd_bg = '0;
  logic [1:0]  cmd_bank = '0;
  logic [17:0] cmd_row = '0;
  logic [7:0]  cmd_col = '0;
  logic        resp_valid;
  logic [3:0]  resp_code;
  logic [3:0]  resp_bank;
  logic [15:0] bank_open;
  logic [15:0] cmd_count;
  logic [15:0] err_count;

  always #5 clk = ~clk;

  dram_cmd_responder dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_type(cmd_type),
    .cmd_bg(cmd_bg), .cmd_bank(cmd_bank), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .resp_valid(resp_valid), .resp_code(resp_code), .resp_bank(resp_bank),
    .bank_open(bank_open), .cmd_count(cmd_count), .err_count(err_count)
  );

  localparam bit [1:0] PRE = 2'b00, ACT = 2'b01, RD = 2'b10, WR = 2'b11;

  int checks = 0;
  int errors = 0;

  // Reference model: earliest legal cycle for each dependent command.
  int          cyc;
  bit          m_open  [16];
  bit [17:0]   m_row   [16];
  int          e_act   [16];
  int          e_acc   [16];
  int          e_pre   [16];
  bit          m_prewr [16];
  int          e_ccd   [4];
  int          n_cmd, n_err;
  bit          m_rv;
  bit [3:0]    m_code, m_bank;

  typedef struct {
    int        gap;
    bit [1:0]  ty;
    bit [3:0]  bank;
    bit [17:0] row;
    bit [3:0]  code;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input int gap, input bit [1:0] ty, input bit [3:0] bank,
                     input bit [17:0] row, input bit [3:0] code);
    vec_t v;
    v.gap = gap; v.ty = ty; v.bank = bank; v.row = row; v.code = code;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0; n_cmd = 0; n_err = 0; m_rv = 0; m_code = 0; m_bank = 0;
    for (int b = 0; b < 16; b++) begin
      m_open[b] = 0; m_row[b] = 0; e_act[b] = 0; e_acc[b] = 0;
      e_pre[b] = 0; m_prewr[b] = 0;
    end
    for (int g = 0; g < 4; g++) e_ccd[g] = 0;
  endtask

  task automatic model_cmd(input bit [1:0] ty, input bit [3:0] b,
                           input bit [17:0] row, output bit [3:0] code);
    int g;
    int lim;
    g = int'(b[3:2]);
    code = 0;
    case (ty)
      PRE: begin
        if (m_open[b]) begin
          if (cyc < e_pre[b]) code = m_prewr[b] ? 4'd8 : 4'd7;
          else begin m_open[b] = 0; e_act[b] = cyc + 24; end
        end
      end
      ACT: begin
        if (m_open[b])          code = 1;
        else if (cyc < e_act[b]) code = 2;
        else begin m_open[b] = 1; m_row[b] = row; e_acc[b] = cyc + 24; end
      end
      default: begin
        if (!m_open[b])          code = 3;
        else if (row != m_row[b]) code = 4;
        else if (cyc < e_acc[b]) code = 5;
        else if (cyc < e_ccd[g]) code = 6;
        else begin
          e_ccd[g] = cyc + 8;
          lim = cyc + ((ty == WR) ? 20 : 12);
          if (lim >= e_pre[b]) begin e_pre[b] = lim; m_prewr[b] = (ty == WR); end
        end
      end
    endcase
  endtask

  task automatic check_outputs();
    bit [15:0] exp_open;
    for (int b = 0; b < 16; b++) exp_open[b] = m_open[b];
    chk("resp_valid", int'(resp_valid), int'(m_rv));
    chk("resp_code",  int'(resp_code),  int'(m_code));
    chk("resp_bank",  int'(resp_bank),  int'(m_bank));
    chk("bank_open",  int'(bank_open),  int'(exp_open));
    chk("cmd_count",  int'(cmd_count),  (n_cmd > 65535) ? 65535 : n_cmd);
    chk("err_count",  int'(err_count),  (n_err > 65535) ? 65535 : n_err);
  endtask

  task automatic step(input bit v, input bit [1:0] ty, input bit [3:0] b,
                      input bit [17:0] row);
    bit [3:0] exp;
    cmd_valid = v; cmd_type = ty; cmd_bg = b[3:2]; cmd_bank = b[1:0];
    cmd_row = row; cmd_col = 8'($urandom);
    if (v) begin
      model_cmd(ty, b, row, exp);
      n_cmd++;
      if (exp != 0) n_err++;
      m_code = exp; m_bank = b;
    end
    m_rv = v;
    @(posedge clk); #1;
    check_outputs();
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, PRE, 4'd0, 18'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rv"},   int'(resp_valid), 0);
    chk({tag, "_code"}, int'(resp_code), 0);
    chk({tag, "_bank"}, int'(resp_bank), 0);
    chk({tag, "_open"}, int'(bank_open), 0);
    chk({tag, "_cmd"},  int'(cmd_count), 0);
    chk({tag, "_err"},  int'(err_count), 0);
  endtask

  initial begin
    // gap = idle cycles before the command; codes hand-derived from timings.
    add(0,  ACT, 5, 18'h1234, 0);
    add(23, RD,  5, 18'h1234, 0);   // 24 after ACT
    add(0,  ACT, 6, 18'h1234, 0);
    add(22, RD,  6, 18'h1234, 5);   // 23 after ACT
    add(0,  ACT, 0, 18'd7, 0);
    add(0,  ACT, 1, 18'd7, 0);
    add(0,  ACT, 4, 18'd9, 0);
    add(23, RD,  0, 18'd7, 0);
    add(6,  RD,  1, 18'd7, 6);      // same group, 7 later
    add(20, RD,  0, 18'd7, 0);
    add(6,  RD,  4, 18'd9, 0);      // other group, 7 later
    add(0,  ACT, 3, 18'd3, 0);
    add(23, WR,  3, 18'd3, 0);
    add(18, PRE, 3, 18'd0, 8);      // 19 after WR
    add(0,  PRE, 3, 18'd0, 0);      // 20 after WR
    add(23, ACT, 3, 18'd3, 0);
    add(23, RD,  3, 18'd3, 0);
    add(10, PRE, 3, 18'd0, 7);      // 11 after RD
    add(0,  PRE, 3, 18'd0, 0);      // 12 after RD
    add(0,  ACT, 2, 18'd1, 0);
    add(0,  PRE, 2, 18'd0, 0);
    add(22, ACT, 2, 18'd1, 2);      // 23 after PRE
    add(0,  ACT, 2, 18'd1, 0);      // 24 after PRE
    add(0,  ACT, 2, 18'd1, 1);
    add(0,  RD,  7, 18'd0, 3);
    add(23, RD,  2, 18'd2, 4);
    add(0,  PRE, 8, 18'd0, 0);      // closed bank: no tRP
    add(0,  ACT, 8, 18'd5, 0);

    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      idle(tbl[i].gap);
      step(1'b1, tbl[i].ty, tbl[i].bank, tbl[i].row);
      chk($sformatf("vec%0d", i), int'(resp_code), int'(tbl[i].code));
    end

    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 9) != 0, 2'($urandom), 4'($urandom_range(0, 5)),
           18'($urandom_range(0, 1)));

    // Mid-stream async reset: outputs must clear before any clock edge.
    step(1'b1, ACT, 4'd12, 18'd1);
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();

    step(1'b1, ACT, 4'd9, 18'h3FFFF);
    chk("post_rst_act", int'(resp_code), 0);
    idle(23);
    step(1'b1, RD, 4'd9, 18'h3FFFF);
    chk("post_rst_rd", int'(resp_code), 0);

    for (int i = 0; i < 66000; i++)
      step(1'b1, 2'($urandom), 4'($urandom_range(0, 7)), 18'($urandom_range(0, 1)));
    chk("cmd_saturate", int'(cmd_count), 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
